eeprom_master: RTL and testbench

EEPROM_MASTER -- requirements
Module: eeprom_master

---
 rtl/eeprom_master_pkg.sv | 35 +++
 rtl/eeprom_master_tick.sv | 28 ++
 rtl/eeprom_master.sv | 262 ++++++++++++++++++++++++++
 tb/tb_eeprom_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_master_pkg.sv
// Shared types, bus command bytes and byte-sequence helper for the EEPROM master.
package eeprom_master_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_START   = 4'd1,
        ST_SEND    = 4'd2,
        ST_ACK_IN  = 4'd3,
        ST_RESTART = 4'd4,
        ST_RECV    = 4'd5,
        ST_ACK_OUT = 4'd6,
        ST_STOP    = 4'd7,
        ST_FINISH  = 4'd8
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'hA0;
    localparam logic [7:0] CMD_READ  = 8'hA1;
    localparam logic [1:0] IDX_LAST  = 2'd3;

    // Byte placed on the bus for a given position in the transaction.
    function automatic logic [7:0] tx_byte(input logic [1:0]  idx,
                                           input logic        we,
                                           input logic [12:0] addr,
                                           input logic [7:0]  wdata);
        logic [7:0] b;
        case (idx)
            2'd0:    b = CMD_WRITE;
            2'd1:    b = {3'b000, addr[12:8]};
            2'd2:    b = addr[7:0];
            default: b = we ? wdata : CMD_READ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eeprom_master_tick.sv
// SCL half-period timer: down-counter that pulses tick on terminal count while enabled.
module eeprom_master_tick #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(HALF_PERIOD - 1);

    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr || !en || (count_q == '0)) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_q - 8'd1;
        end
    end

    assign tick = en && !clr && (count_q == '0);

endmodule

// File: rtl/eeprom_master.sv
// Two-wire EEPROM master: single byte write or random read per host request.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | bus released, waiting for req
// START      | ph0 hold idle level, ph1 SDA low with SCL high
// SEND       | shift one byte MSB first, ph0 SCL low / ph1 SCL high
// ACK_IN     | release SDA for ninth clock, sample slave ACK
// RESTART    | ph0 SCL low, ph1 SCL high, ph2 SDA low (repeated start)
// RECV       | release SDA, shift in eight bits
// ACK_OUT    | master NACK on ninth clock to end the read
// STOP       | ph0 SCL low, ph1 SDA low, ph2 SCL high, ph3 SDA high
// FINISH     | one-cycle done pulse, back to IDLE
module eeprom_master
    import eeprom_master_pkg::*;
#(
    parameter int HALF_PERIOD = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [12:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        nack,
    output logic [7:0]  rdata,
    output logic        scl_out,
    output logic        sda_out,
    input  logic        sda_in
);

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic        tick;

    logic        we_q;
    logic [12:0] addr_q;
    logic [7:0]  wdata_q;
    logic [1:0]  byte_idx_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  tx_q;
    logic [7:0]  rx_q;
    logic        nack_q;
    logic [7:0]  rdata_q;

    logic        bit_end;
    logic        enter_send;
    logic        enter_recv;
    logic [1:0]  load_idx;

    eeprom_master_tick #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (busy),
        .clr     (state_q == ST_IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_START;
                    phase_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (phase_q == 2'd0) begin
                        phase_d = 2'd1;
                    end else begin
                        state_d = ST_SEND;
                        phase_d = '0;
                    end
                end
            end
            ST_SEND: begin
                if (tick) begin
                    if (phase_q == 2'd0) begin
                        phase_d = 2'd1;
                    end else begin
                        phase_d = '0;
                        if (bit_cnt_q == '0) state_d = ST_ACK_IN;
                    end
                end
            end
            ST_ACK_IN: begin
                if (tick) begin
                    if (phase_q == 2'd0) begin
                        phase_d = 2'd1;
                    end else begin
                        phase_d = '0;
                        if (sda_in)                              state_d = ST_STOP;
                        else if (byte_idx_q == IDX_LAST)         state_d = we_q ? ST_STOP : ST_RECV;
                        else if (!we_q && (byte_idx_q == 2'd2))  state_d = ST_RESTART;
                        else                                     state_d = ST_SEND;
                    end
                end
            end
            ST_RESTART: begin
                if (tick) begin
                    if (phase_q != 2'd2) begin
                        phase_d = phase_q + 2'd1;
                    end else begin
                        state_d = ST_SEND;
                        phase_d = '0;
                    end
                end
            end
            ST_RECV: begin
                if (tick) begin
                    if (phase_q == 2'd0) begin
                        phase_d = 2'd1;
                    end else begin
                        phase_d = '0;
                        if (bit_cnt_q == '0) state_d = ST_ACK_OUT;
                    end
                end
            end
            ST_ACK_OUT: begin
                if (tick) begin
                    if (phase_q == 2'd0) begin
                        phase_d = 2'd1;
                    end else begin
                        state_d = ST_STOP;
                        phase_d = '0;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (phase_q != 2'd3) begin
                        phase_d = phase_q + 2'd1;
                    end else begin
                        state_d = ST_FINISH;
                        phase_d = '0;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // STOP ph0 keeps SDA released so a NACKed bus never falls while SCL is still high.
    always_comb begin
        scl_out = 1'b1;
        sda_out = 1'b1;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_START: begin
                sda_out = (phase_q == 2'd0);
            end
            ST_SEND: begin
                scl_out = (phase_q == 2'd1);
                sda_out = tx_q[7];
            end
            ST_ACK_IN, ST_RECV, ST_ACK_OUT: begin
                scl_out = (phase_q == 2'd1);
            end
            ST_RESTART: begin
                scl_out = (phase_q != 2'd0);
                sda_out = (phase_q != 2'd2);
            end
            ST_STOP: begin
                scl_out = phase_q[1];
                sda_out = (phase_q == 2'd0) || (phase_q == 2'd3);
            end
            ST_FINISH: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Tick during the SCL-high phase is the last clk of that half-period.
    assign bit_end    = tick && (phase_q == 2'd1);
    assign enter_send = (state_d == ST_SEND) && (state_q != ST_SEND);
    assign enter_recv = (state_d == ST_RECV) && (state_q != ST_RECV);
    assign load_idx   = (state_q == ST_ACK_IN) ? (byte_idx_q + 2'd1) : byte_idx_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            byte_idx_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            nack_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if ((state_q == ST_IDLE) && req) begin
                we_q       <= we;
                addr_q     <= addr;
                wdata_q    <= wdata;
                byte_idx_q <= '0;
                nack_q     <= 1'b0;
            end

            if (enter_send) begin
                tx_q      <= tx_byte(load_idx, we_q, addr_q, wdata_q);
                bit_cnt_q <= 3'd7;
            end else if (enter_recv) begin
                bit_cnt_q <= 3'd7;
            end else if (bit_end && ((state_q == ST_SEND) || (state_q == ST_RECV))
                         && (bit_cnt_q != '0)) begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
                tx_q      <= {tx_q[6:0], 1'b0};
            end

            if ((state_q == ST_RECV) && bit_end) begin
                rx_q <= {rx_q[6:0], sda_in};
            end

            if ((state_q == ST_ACK_IN) && bit_end) begin
                nack_q <= sda_in;
                if (!sda_in && (byte_idx_q != IDX_LAST)) begin
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
            end

            if ((state_q == ST_STOP) && tick && (phase_q == 2'd3) && !we_q && !nack_q) begin
                rdata_q <= rx_q;
            end
        end
    end

    assign nack  = nack_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_eeprom_master.sv
// Directed bench for eeprom_master with a behavioural two-wire EEPROM on the bus.
module tb_eeprom_master;
    import eeprom_master_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        nack;
    logic [7:0]  rdata;
    logic        scl_out;
    logic        sda_out;
    logic        sda_in;

    logic        sl_drv;
    logic        slave_en;

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;

    assign sda_in = sda_out & sl_drv;

    eeprom_master #(.HALF_PERIOD(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .nack    (nack),
        .rdata   (rdata),
        .scl_out (scl_out),
        .sda_out (sda_out),
        .sda_in  (sda_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // EEPROM model: 8K byte array, ACKs control byte 1010000x, single-byte read.
    logic [7:0]  mem [0:8191];
    logic [7:0]  logb [$];
    int          n_start, n_stop;
    int          m_mode, bit_n, byte_n;
    logic [7:0]  m_sh;
    logic        m_ack, m_rw;
    logic [12:0] m_ptr;
    logic        m_scl, m_sda;

    always @(negedge clk) begin : eeprom_model
        logic bus;
        bus = sda_out & sl_drv;
        if (m_scl && scl_out && m_sda && !bus) begin
            n_start++;
            m_mode = 1; bit_n = 0; byte_n = 0; sl_drv = 1'b1;
        end else if (m_scl && scl_out && !m_sda && bus) begin
            n_stop++;
            m_mode = 0; sl_drv = 1'b1;
        end else if (!m_scl && scl_out) begin
            if (m_mode != 0) bit_n++;
            if (m_mode == 1 && bit_n <= 8) m_sh = {m_sh[6:0], bus};
            if (m_mode == 1 && bit_n == 8) begin
                logb.push_back(m_sh);
                case (byte_n)
                    0: begin m_ack = slave_en && (m_sh[7:1] == 7'h50); m_rw = m_sh[0]; end
                    1: begin m_ptr[12:8] = m_sh[4:0]; m_ack = slave_en; end
                    2: begin m_ptr[7:0] = m_sh; m_ack = slave_en; end
                    default: begin if (slave_en) mem[m_ptr] = m_sh; m_ack = slave_en; end
                endcase
                byte_n++;
            end
        end else if (m_scl && !scl_out) begin
            if (m_mode == 1) begin
                if (bit_n == 8) sl_drv = !m_ack;
                else if (bit_n == 9) begin
                    sl_drv = 1'b1; bit_n = 0;
                    if (!m_ack) m_mode = 0;
                    else if (m_rw && byte_n == 1) begin
                        m_mode = 2; m_sh = mem[m_ptr]; sl_drv = m_sh[7];
                    end
                end
            end else if (m_mode == 2) begin
                if (bit_n < 8) begin m_sh = {m_sh[6:0], 1'b0}; sl_drv = m_sh[7]; end
                else if (bit_n == 8) sl_drv = 1'b1;
                else begin sl_drv = 1'b1; m_mode = 0; bit_n = 0; end
            end
        end
        m_scl = scl_out;
        m_sda = bus;
    end

    // Bus rules: SDA may move under a high SCL only for start/restart/stop; done never with busy.
    logic p_scl, p_sda;
    always @(negedge clk) begin
        if (reset_n) begin
            if (done && busy) viol++;
            if (scl_out && p_scl && (sda_out != p_sda)
                && !(dut.state_q inside {ST_START, ST_RESTART, ST_STOP})) viol++;
        end
        p_scl = scl_out;
        p_sda = sda_out;
    end

    task automatic run_txn(input logic t_we, input logic [12:0] t_addr, input logic [7:0] t_wdata,
                           input int pulse_at, output logic seen_done);
        int cyc;
        logb.delete();
        n_start = 0;
        n_stop  = 0;
        @(negedge clk);
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
        @(negedge clk);
        req = 1'b0;
        seen_done = 1'b0;
        cyc = 0;
        while (!seen_done && cyc < 4000) begin
            if (cyc == pulse_at) begin
                req = 1'b1; we = ~t_we; addr = 13'h0ABC; wdata = 8'h11;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (done) seen_done = 1'b1;
        end
        req = 1'b0;
    endtask

    task automatic expect_log(input string tag, input int n, input logic [31:0] exp_word);
        logic [31:0] got;
        chk({tag, "_nbytes"}, logb.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < logb.size()) ? {24'h0, logb[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s_b%0d", tag, i), got, {24'h0, exp_word[31-8*i -: 8]});
        end
    endtask

    logic ok;
    int   busy_cnt, done_cnt;

    initial begin
        reset_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        slave_en = 1'b1; sl_drv = 1'b1;
        m_scl = 1'b1; m_sda = 1'b1; m_mode = 0; bit_n = 0; byte_n = 0;
        m_sh = '0; m_ack = 1'b0; m_rw = 1'b0; m_ptr = '0;
        p_scl = 1'b1; p_sda = 1'b1; n_start = 0; n_stop = 0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_scl",   scl_out, 1);
        chk("rst_sda",   sda_out, 1);
        chk("rst_busy",  busy,    0);
        chk("rst_done",  done,    0);
        chk("rst_nack",  nack,    0);
        chk("rst_rdata", rdata,   8'h00);
        reset_n = 1'b1;
        @(negedge clk);

        // Write with a stray req mid-transaction.
        run_txn(1'b1, 13'h0123, 8'h5A, 40, ok);
        chk("wr1_done", ok, 1);
        chk("wr1_nack", nack, 0);
        expect_log("wr1", 4, 32'hA0_01_23_5A);
        chk("wr1_starts", n_start, 1);
        chk("wr1_stops",  n_stop,  1);
        chk("wr1_mem",    mem[13'h0123], 8'h5A);
        busy_cnt = 0; done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        chk("wr1_no_queue",   busy_cnt, 0);
        chk("wr1_done_width", done_cnt, 0);

        run_txn(1'b0, 13'h0123, 8'h00, -1, ok);
        chk("rd1_done",   ok, 1);
        chk("rd1_nack",   nack, 0);
        chk("rd1_rdata",  rdata, 8'h5A);
        expect_log("rd1", 4, 32'hA0_01_23_A1);
        chk("rd1_starts", n_start, 2);

        // No slave on the bus.
        slave_en = 1'b0;
        run_txn(1'b1, 13'h0040, 8'hEE, -1, ok);
        chk("ns_done",  ok, 1);
        chk("ns_nack",  nack, 1);
        chk("ns_rdata", rdata, 8'h5A);
        expect_log("ns", 1, 32'hA0_00_00_00);
        chk("ns_stops", n_stop, 1);
        slave_en = 1'b1;

        // Top of the address space.
        run_txn(1'b1, 13'h1FFF, 8'hC3, -1, ok);
        chk("wr2_done", ok, 1);
        chk("wr2_nack", nack, 0);
        expect_log("wr2", 4, 32'hA0_1F_FF_C3);
        run_txn(1'b0, 13'h1FFF, 8'h00, -1, ok);
        chk("rd2_done",  ok, 1);
        chk("rd2_nack",  nack, 0);
        chk("rd2_rdata", rdata, 8'hC3);

        // Abort mid-SEND by reset, stray req while busy.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 13'h0200; wdata = 8'h77;
        @(negedge clk);
        req = 1'b0;
        repeat (30) @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 13'h0ABC;
        @(negedge clk);
        req = 1'b0;
        repeat (60) @(negedge clk);
        chk("ab_busy_before", busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("ab_scl",   scl_out, 1);
        chk("ab_sda",   sda_out, 1);
        chk("ab_busy",  busy,    0);
        chk("ab_done",  done,    0);
        chk("ab_rdata", rdata,   8'h00);
        reset_n = 1'b1;
        busy_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk("ab_idle", busy_cnt, 0);

        run_txn(1'b1, 13'h0300, 8'h99, -1, ok);
        chk("wr3_done", ok, 1);
        chk("wr3_nack", nack, 0);
        expect_log("wr3", 4, 32'hA0_03_00_99);
        run_txn(1'b0, 13'h0300, 8'h00, -1, ok);
        chk("rd3_done",  ok, 1);
        chk("rd3_nack",  nack, 0);
        chk("rd3_rdata", rdata, 8'h99);

        chk("bus_rules", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
